// File: rtl/interrupt_scheduler.sv
// interrupt_scheduler: latches four interrupt sources, masks them with IE/IP and picks one winner.
// It hands the winner's vector to the CPU at an instruction boundary and tracks two nesting levels.
module interrupt_scheduler #(
  parameter logic [7:0] VEC_BASE   = 8'h03,
  parameter logic [7:0] VEC_STRIDE = 8'h08,
  parameter bit         REQ_EDGE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [4:0] ie,
  input  logic [3:0] ip,
  input  logic       inst_boundary,
  input  logic       ack,
  input  logic       reti,
  output logic       int_pend,
  output logic [7:0] vector,
  output logic [1:0] src,
  output logic [3:0] clr,
  output logic [1:0] in_service
);
  typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;
  state_t state, state_n;
  logic [3:0] req_q, pend, pend_n, ev, elig, hi, grp, clr_n, src_oh;
  logic [1:0] win, src_n, is_ret, in_service_n;
  logic [7:0] vector_n;
  logic       win_hi, admit, ip_q, ip_n, int_pend_n;
  always_comb begin
    ev = REQ_EDGE ? req & ~req_q : req;
    elig = pend & ie[3:0] & {4{ie[4]}};
    hi = elig & ip;
    win_hi = |hi;
    grp = win_hi ? hi : elig;
    win = grp[0] ? 2'd0 : grp[1] ? 2'd1 : grp[2] ? 2'd2 : 2'd3;
    admit = (|elig) && (win_hi ? !in_service[1] : in_service == 2'b00);
    src_oh = 4'b0001 << src;
    // RETI retires the highest active level before any new level is set
    is_ret = reti ? (in_service[1] ? {1'b0, in_service[0]} : 2'b00) : in_service;
    state_n = state;
    int_pend_n = int_pend;
    src_n = src;
    vector_n = vector;
    ip_n = ip_q;
    clr_n = 4'b0000;
    pend_n = pend | ev;
    in_service_n = is_ret;
    case (state)
      IDLE: if (admit && inst_boundary) begin
        state_n = REQ;
        int_pend_n = 1'b1;
        src_n = win;
        vector_n = VEC_BASE + VEC_STRIDE * {6'd0, win};
        ip_n = ip[win];
      end
      REQ: if (ack) begin
        state_n = ACK;
        clr_n = src_oh;
      end else if (!ie[4] || !ie[src]) begin
        state_n = IDLE;
        int_pend_n = 1'b0;
      end
      ACK: begin
        state_n = IDLE;
        int_pend_n = 1'b0;
        pend_n = (pend & ~src_oh) | ev;
        in_service_n = is_ret | (ip_q ? 2'b10 : 2'b01);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= '0;
      pend <= '0;
      int_pend <= 1'b0;
      vector <= VEC_BASE;
      src <= '0;
      clr <= '0;
      in_service <= '0;
      ip_q <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= req;
      pend <= pend_n;
      int_pend <= int_pend_n;
      vector <= vector_n;
      src <= src_n;
      clr <= clr_n;
      in_service <= in_service_n;
      ip_q <= ip_n;
    end
  end
endmodule

// File: tb/tb_interrupt_scheduler.sv
// tb_interrupt_scheduler: directed vector table plus hand sequences for abort, same-cycle set/clear and async reset.
module tb_interrupt_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, ip, clr;
  logic [4:0] ie;
  logic       inst_boundary, ack, reti, int_pend;
  logic [7:0] vector;
  logic [1:0] src, in_service;
  int total = 0;
  int bad = 0;

  interrupt_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ie(ie), .ip(ip),
    .inst_boundary(inst_boundary), .ack(ack), .reti(reti),
    .int_pend(int_pend), .vector(vector), .src(src), .clr(clr), .in_service(in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ip;
    logic       bnd;
    logic       ack;
    logic       reti;
    logic       e_pend;
    logic [1:0] e_src;
    logic [7:0] e_vec;
    logic [3:0] e_clr;
    logic [1:0] e_is;
  } row_t;
  row_t tbl[28];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic p, input logic [1:0] s, input logic [7:0] v,
                     input logic [3:0] c, input logic [1:0] is);
    total++;
    if ({int_pend, src, vector, clr, in_service} !== {p, s, v, c, is}) begin
      bad++;
      $display("FAIL %s: got pend=%b src=%0d vec=%h clr=%b is=%b, want pend=%b src=%0d vec=%h clr=%b is=%b",
               name, int_pend, src, vector, clr, in_service, p, s, v, c, is);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0110, 4'b0000, 1, 0, 0, 0, 0, 8'h03, 4'b0000, 2'b00};
    tbl[1]  = '{4'b0000, 4'b0000, 1, 0, 0, 1, 1, 8'h0B, 4'b0000, 2'b00};
    tbl[2]  = '{4'b0000, 4'b0000, 1, 0, 0, 1, 1, 8'h0B, 4'b0000, 2'b00};
    tbl[3]  = '{4'b0000, 4'b0000, 1, 1, 0, 1, 1, 8'h0B, 4'b0010, 2'b00};
    tbl[4]  = '{4'b0000, 4'b0000, 1, 0, 0, 0, 1, 8'h0B, 4'b0000, 2'b01};
    tbl[5]  = '{4'b0000, 4'b0000, 1, 0, 1, 0, 1, 8'h0B, 4'b0000, 2'b00};
    tbl[6]  = '{4'b0000, 4'b0000, 1, 0, 0, 1, 2, 8'h13, 4'b0000, 2'b00};
    tbl[7]  = '{4'b0000, 4'b0000, 1, 1, 0, 1, 2, 8'h13, 4'b0100, 2'b00};
    tbl[8]  = '{4'b0000, 4'b0000, 1, 0, 0, 0, 2, 8'h13, 4'b0000, 2'b01};
    tbl[9]  = '{4'b0000, 4'b0000, 1, 0, 1, 0, 2, 8'h13, 4'b0000, 2'b00};
    tbl[10] = '{4'b1001, 4'b1000, 1, 0, 0, 0, 2, 8'h13, 4'b0000, 2'b00};
    tbl[11] = '{4'b0000, 4'b1000, 1, 0, 0, 1, 3, 8'h1B, 4'b0000, 2'b00};
    tbl[12] = '{4'b0000, 4'b1000, 1, 1, 0, 1, 3, 8'h1B, 4'b1000, 2'b00};
    tbl[13] = '{4'b0000, 4'b1000, 1, 0, 0, 0, 3, 8'h1B, 4'b0000, 2'b10};
    tbl[14] = '{4'b0000, 4'b1000, 1, 0, 0, 0, 3, 8'h1B, 4'b0000, 2'b10};
    tbl[15] = '{4'b0000, 4'b1000, 1, 0, 1, 0, 3, 8'h1B, 4'b0000, 2'b00};
    tbl[16] = '{4'b0000, 4'b1000, 0, 0, 0, 0, 3, 8'h1B, 4'b0000, 2'b00};
    tbl[17] = '{4'b0000, 4'b1000, 1, 0, 0, 1, 0, 8'h03, 4'b0000, 2'b00};
    tbl[18] = '{4'b0000, 4'b1000, 1, 1, 0, 1, 0, 8'h03, 4'b0001, 2'b00};
    tbl[19] = '{4'b0000, 4'b1000, 1, 0, 0, 0, 0, 8'h03, 4'b0000, 2'b01};
    tbl[20] = '{4'b0001, 4'b0001, 1, 0, 0, 0, 0, 8'h03, 4'b0000, 2'b01};
    tbl[21] = '{4'b0000, 4'b0001, 1, 0, 0, 1, 0, 8'h03, 4'b0000, 2'b01};
    tbl[22] = '{4'b0000, 4'b0001, 1, 1, 0, 1, 0, 8'h03, 4'b0001, 2'b01};
    tbl[23] = '{4'b0000, 4'b0001, 1, 0, 0, 0, 0, 8'h03, 4'b0000, 2'b11};
    tbl[24] = '{4'b0000, 4'b0001, 1, 0, 1, 0, 0, 8'h03, 4'b0000, 2'b01};
    tbl[25] = '{4'b0000, 4'b0001, 1, 0, 1, 0, 0, 8'h03, 4'b0000, 2'b00};
    tbl[26] = '{4'b0000, 4'b0001, 1, 0, 1, 0, 0, 8'h03, 4'b0000, 2'b00};
    tbl[27] = '{4'b0000, 4'b0001, 1, 1, 0, 0, 0, 8'h03, 4'b0000, 2'b00};

    rst_n = 1'b0;
    req = '0; ie = 5'h1F; ip = '0; inst_boundary = 1'b1; ack = 1'b0; reti = 1'b0;
    cyc(); cyc();
    chk("reset", 0, 0, 8'h03, 4'b0000, 2'b00);
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      req = tbl[i].req; ip = tbl[i].ip; inst_boundary = tbl[i].bnd; ack = tbl[i].ack; reti = tbl[i].reti;
      cyc();
      chk($sformatf("row%0d", i), tbl[i].e_pend, tbl[i].e_src, tbl[i].e_vec, tbl[i].e_clr, tbl[i].e_is);
    end
    req = '0; ip = '0; inst_boundary = 1'b1; ack = 1'b0; reti = 1'b0;

    // EA dropped while requesting: abort, keep pending, reissue on re-enable
    req = 4'b0010; cyc(); chk("abort_pend", 0, 0, 8'h03, 4'b0000, 2'b00);
    req = 4'b0000; cyc(); chk("abort_req", 1, 1, 8'h0B, 4'b0000, 2'b00);
    ie = 5'h0F;    cyc(); chk("abort_drop", 0, 1, 8'h0B, 4'b0000, 2'b00);
    cyc();                chk("abort_hold", 0, 1, 8'h0B, 4'b0000, 2'b00);
    ie = 5'h1F;    cyc(); chk("abort_reissue", 1, 1, 8'h0B, 4'b0000, 2'b00);

    // new event on src1 during its own ACK cycle keeps it pending
    ack = 1'b1;                cyc(); chk("sc_ack", 1, 1, 8'h0B, 4'b0010, 2'b00);
    ack = 1'b0; req = 4'b0010; cyc(); chk("sc_done", 0, 1, 8'h0B, 4'b0000, 2'b01);
    req = 4'b0000; reti = 1'b1; cyc(); chk("sc_reti", 0, 1, 8'h0B, 4'b0000, 2'b00);
    reti = 1'b0;               cyc(); chk("sc_regrant", 1, 1, 8'h0B, 4'b0000, 2'b00);
    ack = 1'b1;                cyc(); chk("sc_ack2", 1, 1, 8'h0B, 4'b0010, 2'b00);
    ack = 1'b0;                cyc(); chk("sc_done2", 0, 1, 8'h0B, 4'b0000, 2'b01);
    reti = 1'b1;               cyc(); chk("sc_idle", 0, 1, 8'h0B, 4'b0000, 2'b00);
    reti = 1'b0;

    // asynchronous reset while a request is outstanding
    req = 4'b0100; cyc();
    req = 4'b0000; cyc(); chk("rst_pre", 1, 2, 8'h13, 4'b0000, 2'b00);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 0, 0, 8'h03, 4'b0000, 2'b00);
    cyc();
    rst_n = 1'b1;
    cyc(); chk("rst_after", 0, 0, 8'h03, 4'b0000, 2'b00);
    cyc(); chk("rst_idle", 0, 0, 8'h03, 4'b0000, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
